// File: rtl/floor_call_scheduler.sv
// Floor call scheduler: synchronises car-call buttons and latches each rising edge
// into a pending-request register. It picks the next target floor with SCAN ordering
// and sends the car to a home floor after an idle timeout.
module floor_call_scheduler #(
  parameter logic [31:0] HOME_TIMEOUT = 32'd50,
  parameter logic [3:0]  HOME_FLOOR   = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] call_btn,
  input  logic [3:0] current_floor,
  input  logic       at_rest,
  output logic [3:0] requested_floor,
  output logic [7:0] pending,
  output logic [1:0] direction,
  output logic       homing
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HOME = 2'b01;
  localparam logic [1:0] S_UP   = 2'b10;
  localparam logic [1:0] S_DOWN = 2'b11;

  logic [7:0]  sync_a, sync_b, btn_prev;
  logic [7:0]  rise, clear_mask;
  logic [3:0]  cf;
  logic        have_above, have_below, pick_up;
  logic [3:0]  low_above, high_below;
  logic [1:0]  state, state_next, idle_dir;
  logic [3:0]  req_next;
  logic [31:0] idle_cnt, cnt_next;

  // Clamp an out-of-range floor report to the top floor for every comparison.
  always_comb begin
    cf = (current_floor > 4'd8) ? 4'd8 : current_floor;
  end

  // Rising edge on the synchronised button, and the bit of the floor the car rests at.
  always_comb begin
    rise       = sync_b & ~btn_prev;
    clear_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (at_rest && (current_floor == 4'(i + 1))) clear_mask[i] = 1'b1;
    end
  end

  // Two-flop synchroniser followed by the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      btn_prev <= '0;
    end else begin
      sync_a   <= call_btn;
      sync_b   <= sync_a;
      btn_prev <= sync_b;
    end
  end

  // Latch new presses and drop the request of the floor the car rests at (clear wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | rise) & ~clear_mask;
  end

  // Nearest pending floor at or above, and at or below, the car.
  always_comb begin
    have_above = 1'b0;
    low_above  = 4'd0;
    have_below = 1'b0;
    high_below = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i] && (4'(i + 1) >= cf)) begin
        have_above = 1'b1;
        low_above  = 4'(i + 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (pending[i] && (4'(i + 1) <= cf)) begin
        have_below = 1'b1;
        high_below = 4'(i + 1);
      end
    end
    // Equal distance (including a request at the car's own floor) favours UP.
    pick_up  = have_above &&
               (!have_below || ((low_above - cf) <= (cf - high_below)));
    idle_dir = pick_up ? S_UP : S_DOWN;
  end

  // Scheduler state transition, idle counter and target selection for the next state.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          state_next = idle_dir;
        end else if (at_rest) begin
          if ((({1'b0, idle_cnt} + 33'd1) >= {1'b0, HOME_TIMEOUT}) && (cf != HOME_FLOOR))
            state_next = S_HOME;
          else
            cnt_next = (idle_cnt == 32'hFFFF_FFFF) ? idle_cnt : idle_cnt + 32'd1;
        end
      end
      S_UP: begin
        if (pending == 8'd0)  state_next = S_IDLE;
        else if (!have_above) state_next = S_DOWN;
      end
      S_DOWN: begin
        if (pending == 8'd0)  state_next = S_IDLE;
        else if (!have_below) state_next = S_UP;
      end
      S_HOME: begin
        if (|pending)                          state_next = idle_dir;
        else if (at_rest && (cf == HOME_FLOOR)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_UP:    req_next = low_above;
      S_DOWN:  req_next = high_below;
      S_HOME:  req_next = HOME_FLOOR;
      default: req_next = cf;
    endcase
  end

  // Registered scheduler state, target floor and idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      requested_floor <= 4'd0;
      idle_cnt        <= '0;
    end else begin
      state           <= state_next;
      requested_floor <= req_next;
      idle_cnt        <= cnt_next;
    end
  end

  // Direction and homing flag come straight from the state register.
  always_comb begin
    direction = state;
    homing    = (state == S_HOME);
  end

endmodule
